// File: rtl/user_input_conditioner.sv
// Synchronise, debounce and edge-detect DE0-Nano-SoC buttons/switches; sticky W1C pending bits drive a maskable irq.
// Latency 2+DEBOUNCE_CYCLES from raw sample to output/pulse; pending +1, irq +2. No backpressure: events latch until cleared.
module user_input_conditioner #(
    parameter int NUM_KEYS        = 2,
    parameter int NUM_SWITCHES    = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SETTLE_CYCLES   = DEBOUNCE_CYCLES + 2
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [NUM_KEYS-1:0]              key_raw,
    input  logic [NUM_SWITCHES-1:0]          switch_raw,
    output logic [NUM_KEYS-1:0]              keys_o,
    output logic [NUM_SWITCHES-1:0]          switches_o,
    output logic [NUM_KEYS-1:0]              key_press,
    output logic [NUM_KEYS-1:0]              key_release,
    output logic [NUM_SWITCHES-1:0]          switch_change,
    input  logic [NUM_KEYS+NUM_SWITCHES-1:0] irq_mask,
    input  logic [NUM_KEYS+NUM_SWITCHES-1:0] event_clr,
    output logic [NUM_KEYS+NUM_SWITCHES-1:0] event_pend,
    output logic                             irq
);
    localparam int N  = NUM_KEYS + NUM_SWITCHES;
    localparam int CW = ($clog2(DEBOUNCE_CYCLES) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_TERM  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [SW-1:0] SETTLE_TC = SW'(SETTLE_CYCLES);
    // Keys idle high, switches idle low; keys occupy the low bits.
    localparam logic [N-1:0]  RST_LVL   = {{NUM_SWITCHES{1'b0}}, {NUM_KEYS{1'b1}}};

    logic [N-1:0]    raw;
    logic [N-1:0]    sync1;
    logic [N-1:0]    sync2;
    logic [N-1:0]    deb;
    logic [N-1:0]    deb_q;
    logic [CW-1:0]   cnt [N];
    logic [SW-1:0]   settle_cnt;
    logic            armed;
    logic [N-1:0]    ev;

    assign raw = {switch_raw, key_raw};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= RST_LVL;
            sync2 <= RST_LVL;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Any return of the synchronised level to the accepted one restarts the count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deb <= RST_LVL;
            for (int i = 0; i < N; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_TERM) begin
                    deb[i] <= sync2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            settle_cnt <= '0;
            armed      <= 1'b0;
        end else if (!armed) begin
            if (settle_cnt == SETTLE_TC) begin
                armed <= 1'b1;
            end else begin
                settle_cnt <= settle_cnt + 1'b1;
            end
        end
    end

    // Output stage: level and its pulse update on the same edge so they stay coincident.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deb_q         <= RST_LVL;
            key_press     <= '0;
            key_release   <= '0;
            switch_change <= '0;
        end else begin
            deb_q <= deb;
            if (armed) begin
                key_press     <= deb_q[NUM_KEYS-1:0] & ~deb[NUM_KEYS-1:0];
                key_release   <= ~deb_q[NUM_KEYS-1:0] & deb[NUM_KEYS-1:0];
                switch_change <= deb_q[N-1:NUM_KEYS] ^ deb[N-1:NUM_KEYS];
            end else begin
                key_press     <= '0;
                key_release   <= '0;
                switch_change <= '0;
            end
        end
    end

    assign keys_o     = deb_q[NUM_KEYS-1:0];
    assign switches_o = deb_q[N-1:NUM_KEYS];
    assign ev         = {switch_change, key_press};

    // Set has priority over a simultaneous clear so no event is lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            event_pend <= '0;
            irq        <= 1'b0;
        end else begin
            event_pend <= (event_pend & ~event_clr) | ev;
            irq        <= |(event_pend & irq_mask);
        end
    end
endmodule

// File: tb/tb_user_input_conditioner.sv
// Directed bench for user_input_conditioner with a pulse scoreboard checked by an independent monitor.
module tb_user_input_conditioner;
    logic       clk;
    logic       reset_n;
    logic [1:0] key_raw;
    logic [3:0] switch_raw;
    logic [1:0] keys_o;
    logic [3:0] switches_o;
    logic [1:0] key_press;
    logic [1:0] key_release;
    logic [3:0] switch_change;
    logic [5:0] irq_mask;
    logic [5:0] event_clr;
    logic [5:0] event_pend;
    logic       irq;

    typedef struct {
        int         cyc;
        logic [1:0] kp;
        logic [1:0] kr;
        logic [3:0] sc;
    } pulse_t;

    pulse_t exp_q[$];
    int     nvec = 0;
    int     nerr = 0;
    int     cyc  = 0;
    int     r, n, m, g;

    user_input_conditioner #(
        .NUM_KEYS(2), .NUM_SWITCHES(4), .DEBOUNCE_CYCLES(8), .SETTLE_CYCLES(10)
    ) dut (
        .clk(clk), .reset_n(reset_n), .key_raw(key_raw), .switch_raw(switch_raw),
        .keys_o(keys_o), .switches_o(switches_o), .key_press(key_press),
        .key_release(key_release), .switch_change(switch_change),
        .irq_mask(irq_mask), .event_clr(event_clr), .event_pend(event_pend), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] expv);
        nvec++;
        if (act !== expv) begin
            nerr++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, expv);
        end
    endtask

    task automatic exp_pulse(input int c, input logic [1:0] kp, input logic [1:0] kr, input logic [3:0] sc);
        pulse_t e;
        e.cyc = c; e.kp = kp; e.kr = kr; e.sc = sc;
        exp_q.push_back(e);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitor: every visible pulse must match the head of the scoreboard, on the expected cycle.
    always @(negedge clk) begin
        pulse_t e;
        if ((key_press | key_release) != 2'b00 || switch_change != 4'b0000) begin
            nvec++;
            if (exp_q.size() == 0) begin
                nerr++;
                $display("FAIL unexpected_pulse at cycle %0d: press=%b release=%b change=%b, expected none",
                         cyc, key_press, key_release, switch_change);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.kp !== key_press || e.kr !== key_release || e.sc !== switch_change) begin
                    nerr++;
                    $display("FAIL pulse at cycle %0d: press=%b release=%b change=%b, expected cycle %0d press=%b release=%b change=%b",
                             cyc, key_press, key_release, switch_change, e.cyc, e.kp, e.kr, e.sc);
                end
            end
        end
        if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            nvec++;
            nerr++;
            e = exp_q.pop_front();
            $display("FAIL missing_pulse: got no pulse by cycle %0d, expected at cycle %0d press=%b release=%b change=%b",
                     cyc, e.cyc, e.kp, e.kr, e.sc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; key_raw = 2'b11; switch_raw = 4'b0101;
        irq_mask = 6'h00; event_clr = 6'h00;
        repeat (3) @(negedge clk);
        chk("rst_keys", 8'(keys_o), 8'h03);
        chk("rst_switches", 8'(switches_o), 8'h00);
        chk("rst_irq", 8'(irq), 8'h00);
        chk("rst_pend", 8'(event_pend), 8'h00);

        // Power-up settle: switches track to 0101 with no event.
        reset_n = 1'b1; r = cyc;
        wait_cyc(r + 10); chk("settle_sw_early", 8'(switches_o), 8'h00);
        wait_cyc(r + 11); chk("settle_sw", 8'(switches_o), 8'h05);
        wait_cyc(r + 14); chk("settle_pend", 8'(event_pend), 8'h00);

        // Clean press of key 0.
        irq_mask = 6'h3F; key_raw = 2'b10; n = cyc;
        exp_pulse(n + 11, 2'b01, 2'b00, 4'b0000);
        wait_cyc(n + 10); chk("key0_early", 8'(keys_o), 8'h03);
        wait_cyc(n + 11); chk("key0_level", 8'(keys_o), 8'h02);
        wait_cyc(n + 12); chk("key0_pend", 8'(event_pend), 8'h01); chk("key0_irq_lag", 8'(irq), 8'h00);
        wait_cyc(n + 13); chk("key0_irq", 8'(irq), 8'h01);
        event_clr = 6'h01; m = cyc;
        wait_cyc(m + 1); event_clr = 6'h00;
        chk("clr_pend", 8'(event_pend), 8'h00); chk("clr_irq_lag", 8'(irq), 8'h01);
        wait_cyc(m + 2); chk("clr_irq", 8'(irq), 8'h00);

        // Key 1 bounces in 3-cycle runs, then settles low.
        for (int b = 0; b < 4; b++) begin
            key_raw[1] = (b % 2 == 1);
            repeat (3) @(negedge clk);
        end
        key_raw[1] = 1'b0; n = cyc;
        exp_pulse(n + 11, 2'b10, 2'b00, 4'b0000);
        wait_cyc(n + 11); chk("bounce_level", 8'(keys_o), 8'h00);

        // Release both keys together.
        wait_cyc(n + 13); key_raw = 2'b11; n = cyc;
        exp_pulse(n + 11, 2'b00, 2'b11, 4'b0000);
        wait_cyc(n + 11); chk("release_both", 8'(keys_o), 8'h03);

        // 7-cycle glitch is rejected.
        wait_cyc(n + 13); key_raw[1] = 1'b0; g = cyc;
        wait_cyc(g + 7); key_raw[1] = 1'b1;
        wait_cyc(g + 20); chk("glitch7", 8'(keys_o), 8'h03);

        // 8-cycle glitch is accepted both ways.
        key_raw[1] = 1'b0; g = cyc;
        exp_pulse(g + 11, 2'b10, 2'b00, 4'b0000);
        exp_pulse(g + 19, 2'b00, 2'b10, 4'b0000);
        wait_cyc(g + 8); key_raw[1] = 1'b1;
        wait_cyc(g + 11); chk("glitch8_low", 8'(keys_o), 8'h01);
        wait_cyc(g + 19); chk("glitch8_high", 8'(keys_o), 8'h03);
        wait_cyc(g + 22); event_clr = 6'h3F;
        @(negedge clk); event_clr = 6'h00;
        @(negedge clk); chk("clrall_pend", 8'(event_pend), 8'h00); chk("clrall_irq", 8'(irq), 8'h00);

        // Masked switch event still latches; unmasking raises irq.
        irq_mask = 6'b101111; switch_raw = 4'b0001; n = cyc;
        exp_pulse(n + 11, 2'b00, 2'b00, 4'b0100);
        wait_cyc(n + 11); chk("sw2_level", 8'(switches_o), 8'h01);
        wait_cyc(n + 12); chk("sw2_pend", 8'(event_pend), 8'h10);
        wait_cyc(n + 14); chk("sw2_masked_irq", 8'(irq), 8'h00);
        irq_mask = 6'h3F; m = cyc;
        wait_cyc(m + 1); chk("sw2_unmask_irq", 8'(irq), 8'h01);
        event_clr = 6'h3F;
        @(negedge clk); event_clr = 6'h00;
        @(negedge clk);

        // Set beats a simultaneous clear.
        key_raw = 2'b10; n = cyc;
        exp_pulse(n + 11, 2'b01, 2'b00, 4'b0000);
        wait_cyc(n + 11); event_clr = 6'h01;
        wait_cyc(n + 12); event_clr = 6'h00; chk("set_wins", 8'(event_pend), 8'h01);
        wait_cyc(n + 13); chk("set_wins_hold", 8'(event_pend), 8'h01);

        // Reset mid-debounce (count 5) of a key release.
        key_raw = 2'b11; n = cyc;
        wait_cyc(n + 7); reset_n = 1'b0;
        #1;
        chk("midrst_keys", 8'(keys_o), 8'h03);
        chk("midrst_pend", 8'(event_pend), 8'h00);
        chk("midrst_irq", 8'(irq), 8'h00);
        repeat (3) @(negedge clk);
        reset_n = 1'b1; r = cyc;
        wait_cyc(r + 10); chk("resettle_sw_early", 8'(switches_o), 8'h00);
        wait_cyc(r + 11); chk("resettle_sw", 8'(switches_o), 8'h01);
        wait_cyc(r + 14); chk("resettle_pend", 8'(event_pend), 8'h00);

        // Rearmed after the new settle window.
        key_raw = 2'b01; n = cyc;
        exp_pulse(n + 11, 2'b10, 2'b00, 4'b0000);
        wait_cyc(n + 12); chk("rearm_pend", 8'(event_pend), 8'h02);
        wait_cyc(n + 15);
        chk("scoreboard_empty", 8'(exp_q.size()), 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/user_input_conditioner.md
Name: user_input_conditioner

Overview:
- Conditions the raw DE0-Nano-SoC push-buttons and slide switches before they drive the soc_system `user_input_keys` / `user_input_switches` PIO ports.
- Per input bit: 2-FF synchroniser, counter-based debounce, edge-event capture.
- Also produces a maskable, sticky interrupt request with write-1-to-clear pending bits, for the interrupt-driven HPS driver.

Parameters:
NUM_KEYS, 2, number of push-button inputs (active-low, idle high)
NUM_SWITCHES, 4, number of slide-switch inputs (active-high)
DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a new level (10 ms at 50 MHz); legal range 2..2^24-1
SETTLE_CYCLES, DEBOUNCE_CYCLES+2, cycles after reset release during which events are suppressed

Ports:
clk  in  1  system clock (50 MHz, same clock as soc_system clk_clk)
reset_n  in  1  asynchronous active-low reset
key_raw  in  NUM_KEYS  raw button pins, asynchronous
switch_raw  in  NUM_SWITCHES  raw switch pins, asynchronous
keys_o  out  NUM_KEYS  debounced keys, polarity preserved; to user_input_keys
switches_o  out  NUM_SWITCHES  debounced switches; to user_input_switches
key_press  out  NUM_KEYS  1-cycle pulse on debounced 1->0 key transition
key_release  out  NUM_KEYS  1-cycle pulse on debounced 0->1 key transition
switch_change  out  NUM_SWITCHES  1-cycle pulse on any debounced switch transition
irq_mask  in  NUM_KEYS+NUM_SWITCHES  1 = pending bit enabled to irq
event_clr  in  NUM_KEYS+NUM_SWITCHES  write-1-to-clear strobe for pending bits
event_pend  out  NUM_KEYS+NUM_SWITCHES  sticky pending events; bits [NUM_KEYS-1:0] = key press, upper bits = switch change
irq  out  1  registered OR of (event_pend & irq_mask)

Behaviour:
- Reset (async assert, sync release handled by the top level):
  - Key sync and debounced regs = all 1s; switch sync and debounced regs = all 0s.
  - All counters = 0; all pulses, event_pend and irq = 0; settle counter = 0; armed = 0.
- Synchroniser: two flops per bit; s = second-stage output. Nothing downstream reads the first stage.
- Debounce, per bit, with stable level d and counter cnt (width clog2(DEBOUNCE_CYCLES)):
  - s == d: cnt <= 0.
  - s != d and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - s != d and cnt == DEBOUNCE_CYCLES-1: d <= s, cnt <= 0, edge pulse asserted that same cycle (registered; visible the cycle after the clock edge that updates d).
  - Any return of s to d before terminal count restarts the count from 0. A glitch of DEBOUNCE_CYCLES-1 cycles or fewer never changes d.
- Latency: a clean raw step appears on keys_o/switches_o exactly 2 + DEBOUNCE_CYCLES cycles after the first clock edge that samples the new level. The pulse is coincident with the output change.
- Edge pulses: key_press when d goes 1->0; key_release when d goes 0->1; switch_change on either direction. Each is exactly 1 cycle wide per accepted transition.
- Settle window:
  - Settle counter increments from reset release until it reaches SETTLE_CYCLES, then sets armed = 1 (sticky until reset).
  - While armed = 0, d still tracks inputs (so switches held high at power-up settle to 1), but edge pulses and event_pend sets are suppressed.
- Pending register, per bit:
  - Set on its event pulse (key_press for keys, switch_change for switches).
  - Cleared on event_clr bit = 1.
  - Set and clear in the same cycle: set wins, bit stays 1.
  - Independent of irq_mask; masked events still latch.
- irq: registered, one cycle after event_pend/irq_mask change. Level stays high until all enabled pending bits clear.
- Reset mid-debounce: counter and d return to reset values immediately; no pulse is emitted; settle window restarts.
- Bits are fully independent. Simultaneous transitions on several bits each produce their own pulse and pending bit in the same cycle.

Test Plan (bench uses DEBOUNCE_CYCLES=8, SETTLE_CYCLES=10):
- Reset, key_raw=2'b11, switch_raw=4'b0101 -> during reset keys_o=2'b11, switches_o=0, irq=0; 10 cycles after release switches_o=4'b0101, no switch_change pulse, event_pend=0.
- After armed, key_raw[0] 1->0 clean, irq_mask=all 1 -> keys_o[0]=0 and 1-cycle key_press[0] exactly 10 cycles later; event_pend[0]=1; irq=1 the next cycle; event_clr[0] pulse -> event_pend=0, irq=0 one cycle after.
- key_raw[1] bounces 0/1 with 3-cycle runs, then settles low -> exactly one key_press[1], 10 cycles after the final settle edge; a 7-cycle low glitch alone -> no change, no pulse.
- switch_raw[2] toggles with irq_mask[4]=0 -> switch_change[2] pulse, event_pend[4]=1, irq stays 0; then set irq_mask[4]=1 -> irq=1 one cycle later.
- A new key_press[0] in the same cycle as event_clr[0]=1 -> event_pend[0] remains 1.
- Assert reset_n=0 at cnt=5 of a pending key change -> keys_o returns to 2'b11 immediately, no pulse, settle window restarts after release.
